// File: rtl/sram_mem_arbiter_if.sv
// sram-like requester bus (req/addr_ok/data_ok) shared by the fetch and data sides of sram_mem_arbiter.
// The master modport is the requester and the slave modport is the arbiter.
interface sram_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  wr;
    logic [DATA_W/8-1:0]   wstrb;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_mem_arbiter.sv
// Shares one single-port SRAM (1-cycle read latency) between the inst and data requesters.
// Default policy is data-first with an inst starvation guard; define ARB_RR_EN for round-robin on conflicts.
module sram_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                resetn,
    sram_mem_arbiter_if.slave   inst,
    sram_mem_arbiter_if.slave   data,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RESP_I = 2'd1;
    localparam logic [1:0] RESP_D = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       grant_i;
    logic       grant_d;
    logic       inst_first;

`ifdef ARB_RR_EN
    // 0 = inst won the last grant; the side not granted last wins a conflict
    logic last_grant;

    assign inst_first = last_grant;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant <= 1'b0;
        end else if (grant_i) begin
            last_grant <= 1'b0;
        end else if (grant_d) begin
            last_grant <= 1'b1;
        end
    end
`else
    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    assign inst_first = (starve_cnt == CNT_MAX);

    // counts consecutive cycles inst wanted the SRAM but lost to data
    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (!inst.req || grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`endif

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (resetn) begin
            if (inst.req && data.req) begin
                grant_i = inst_first;
                grant_d = !inst_first;
            end else begin
                grant_i = inst.req;
                grant_d = data.req;
            end
        end
    end

    assign inst.addr_ok = grant_i;
    assign data.addr_ok = grant_d;

    // only the granted side is steered onto the SRAM, so the idle side's inputs never leak through
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (grant_i) begin
            sram_en    = 1'b1;
            sram_we    = inst.wr ? inst.wstrb : {STRB_W{1'b0}};
            sram_addr  = inst.addr;
            sram_wdata = inst.wdata;
        end else if (grant_d) begin
            sram_en    = 1'b1;
            sram_we    = data.wr ? data.wstrb : {STRB_W{1'b0}};
            sram_addr  = data.addr;
            sram_wdata = data.wdata;
        end
    end

    always_comb begin
        state_next = IDLE;
        if (grant_i) begin
            state_next = RESP_I;
        end else if (grant_d) begin
            state_next = RESP_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // responses are masked by resetn so a transaction in flight when reset hits is dropped
    assign inst.data_ok = resetn && (state == RESP_I);
    assign data.data_ok = resetn && (state == RESP_D);
    assign inst.rdata   = inst.data_ok ? sram_rdata : '0;
    assign data.rdata   = data.data_ok ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Self-checking bench for sram_mem_arbiter: directed cases, then random traffic checked every cycle
// against a transaction-level model of grant, response ownership and SRAM contents.
module tb_sram_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STRB_W     = DATA_W / 8;
    localparam int STARVE_MAX = 8;

    localparam int WIN_N = 0;
    localparam int WIN_I = 1;
    localparam int WIN_D = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    sram_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) inst_bus ();
    sram_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) data_bus ();

    logic              sram_en;
    logic [STRB_W-1:0] sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    sram_mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .inst       (inst_bus),
        .data       (data_bus),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // SRAM macro stand-in: registered read of the pre-write word, byte-masked write
    logic [31:0] sram_mem [0:255];
    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= sram_mem[sram_addr[9:2]];
            sram_mem[sram_addr[9:2]] <= merge(sram_mem[sram_addr[9:2]], sram_wdata, sram_we);
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:255];
    int          exp_win = WIN_N;
    int          pend = WIN_N;
    logic        pend_rd = 1'b0;
    logic [31:0] pend_rdata = '0;
    int          starve = 0;
    logic        last_was_data = 1'b0;

    function automatic int winner();
        if (!resetn) return WIN_N;
        if (inst_bus.req && data_bus.req) begin
`ifdef ARB_RR_EN
            return last_was_data ? WIN_I : WIN_D;
`else
            return (starve == STARVE_MAX) ? WIN_I : WIN_D;
`endif
        end
        if (inst_bus.req) return WIN_I;
        if (data_bus.req) return WIN_D;
        return WIN_N;
    endfunction

    always @(negedge clk) begin
        logic [3:0]  e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_dok_i;
        logic        e_dok_d;
        exp_win = winner();
        e_we = '0;
        e_addr = '0;
        e_wdata = '0;
        if (exp_win == WIN_I) begin
            e_we = inst_bus.wr ? inst_bus.wstrb : 4'h0;
            e_addr = inst_bus.addr;
            e_wdata = inst_bus.wdata;
        end else if (exp_win == WIN_D) begin
            e_we = data_bus.wr ? data_bus.wstrb : 4'h0;
            e_addr = data_bus.addr;
            e_wdata = data_bus.wdata;
        end
        checkOutput("inst_addr_ok", 64'(inst_bus.addr_ok), 64'(exp_win == WIN_I));
        checkOutput("data_addr_ok", 64'(data_bus.addr_ok), 64'(exp_win == WIN_D));
        checkOutput("sram_en", 64'(sram_en), 64'(exp_win != WIN_N));
        checkOutput("sram_we", 64'(sram_we), 64'(e_we));
        checkOutput("sram_addr", 64'(sram_addr), 64'(e_addr));
        checkOutput("sram_wdata", 64'(sram_wdata), 64'(e_wdata));
        e_dok_i = resetn && (pend == WIN_I);
        e_dok_d = resetn && (pend == WIN_D);
        checkOutput("inst_data_ok", 64'(inst_bus.data_ok), 64'(e_dok_i));
        checkOutput("data_data_ok", 64'(data_bus.data_ok), 64'(e_dok_d));
        if (e_dok_i && pend_rd) checkOutput("inst_rdata", 64'(inst_bus.rdata), 64'(pend_rdata));
        if (e_dok_d && pend_rd) checkOutput("data_rdata", 64'(data_bus.rdata), 64'(pend_rdata));
        if (!resetn) begin
            checkOutput("inst_rdata_rst", 64'(inst_bus.rdata), 64'h0);
            checkOutput("data_rdata_rst", 64'(data_bus.rdata), 64'h0);
        end
    end

    always @(posedge clk) begin
        if (!resetn) begin
            pend <= WIN_N;
            pend_rd <= 1'b0;
            starve <= 0;
            last_was_data <= 1'b0;
        end else begin
            pend <= exp_win;
            if (exp_win == WIN_I) begin
                pend_rd <= !inst_bus.wr;
                pend_rdata <= ref_mem[inst_bus.addr[9:2]];
                if (inst_bus.wr)
                    ref_mem[inst_bus.addr[9:2]] <= merge(ref_mem[inst_bus.addr[9:2]], inst_bus.wdata, inst_bus.wstrb);
            end else if (exp_win == WIN_D) begin
                pend_rd <= !data_bus.wr;
                pend_rdata <= ref_mem[data_bus.addr[9:2]];
                if (data_bus.wr)
                    ref_mem[data_bus.addr[9:2]] <= merge(ref_mem[data_bus.addr[9:2]], data_bus.wdata, data_bus.wstrb);
            end else begin
                pend_rd <= 1'b0;
            end
            if (inst_bus.req && exp_win == WIN_D) starve <= (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
            else starve <= 0;
            if (exp_win != WIN_N) last_was_data <= (exp_win == WIN_D);
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic rstn, input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwr, input logic [3:0] dwstrb,
                                 input logic [31:0] daddr, input logic [31:0] dwdata);
        @(posedge clk);
        #1;
        resetn = rstn;
        inst_bus.req = ireq;
        inst_bus.wr = 1'b0;
        inst_bus.wstrb = 4'h0;
        inst_bus.addr = iaddr;
        inst_bus.wdata = 32'h0;
        data_bus.req = dreq;
        data_bus.wr = dwr;
        data_bus.wstrb = dwstrb;
        data_bus.addr = daddr;
        data_bus.wdata = dwdata;
        @(negedge clk);
    endtask

    // a side keeps its request until accepted; idle sides carry garbage fields
    task automatic randomStep();
        @(posedge clk);
        #1;
        if (!inst_bus.req || exp_win == WIN_I) begin
            inst_bus.req = ($urandom_range(0, 2) != 0);
            inst_bus.wr = $urandom_range(0, 1) == 1;
            inst_bus.wstrb = 4'($urandom_range(0, 15));
            inst_bus.addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            inst_bus.wdata = $urandom;
        end
        if (!data_bus.req || exp_win == WIN_D) begin
            data_bus.req = ($urandom_range(0, 2) != 0);
            data_bus.wr = $urandom_range(0, 1) == 1;
            data_bus.wstrb = 4'($urandom_range(0, 15));
            data_bus.addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            data_bus.wdata = $urandom;
        end
        resetn = ($urandom_range(0, 63) != 0);
    endtask

    initial begin
        int inst_resp;
        inst_bus.req = 1'b0;
        inst_bus.wr = 1'b0;
        inst_bus.wstrb = '0;
        inst_bus.addr = '0;
        inst_bus.wdata = '0;
        data_bus.req = 1'b0;
        data_bus.wr = 1'b0;
        data_bus.wstrb = '0;
        data_bus.addr = '0;
        data_bus.wdata = '0;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = '0;
            ref_mem[i] = '0;
        end

        // reset held with both requesting; data writes the word inst reads next
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b1, 32'h1c000000, 1'b1, 1'b1, 4'hf, 32'h1c000000, 32'h02c00000);
            checkOutput("rst_inst_addr_ok", 64'(inst_bus.addr_ok), 64'h0);
            checkOutput("rst_data_addr_ok", 64'(data_bus.addr_ok), 64'h0);
            checkOutput("rst_sram_en", 64'(sram_en), 64'h0);
            checkOutput("rst_data_ok", 64'({inst_bus.data_ok, data_bus.data_ok}), 64'h0);
        end
        applyStimulus(1'b1, 1'b1, 32'h1c000000, 1'b1, 1'b1, 4'hf, 32'h1c000000, 32'h02c00000);
        checkOutput("post_rst_data_addr_ok", 64'(data_bus.addr_ok), 64'h1);
        checkOutput("post_rst_inst_addr_ok", 64'(inst_bus.addr_ok), 64'h0);

        // inst read of the freshly written word
        applyStimulus(1'b1, 1'b1, 32'h1c000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("iread_addr_ok", 64'(inst_bus.addr_ok), 64'h1);
        checkOutput("iread_sram_en", 64'(sram_en), 64'h1);
        checkOutput("iread_sram_we", 64'(sram_we), 64'h0);
        checkOutput("iread_sram_addr", 64'(sram_addr), 64'h1c000000);
        checkOutput("dwrite0_data_ok", 64'(data_bus.data_ok), 64'h1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("iread_data_ok", 64'(inst_bus.data_ok), 64'h1);
        checkOutput("iread_rdata", 64'(inst_bus.rdata), 64'h02c00000);
        checkOutput("iread_data_data_ok", 64'(data_bus.data_ok), 64'h0);

        // data partial write
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hdeadbeef);
        checkOutput("dwrite_addr_ok", 64'(data_bus.addr_ok), 64'h1);
        checkOutput("dwrite_sram_we", 64'(sram_we), 64'h3);
        checkOutput("dwrite_sram_addr", 64'(sram_addr), 64'h100);
        checkOutput("dwrite_sram_wdata", 64'(sram_wdata), 64'hdeadbeef);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("dwrite_data_ok", 64'(data_bus.data_ok), 64'h1);
        checkOutput("dwrite_inst_data_ok", 64'(inst_bus.data_ok), 64'h0);

`ifndef ARB_RR_EN
        // both requesting: 8 data grants, then inst, repeating
        inst_resp = 0;
        for (int k = 0; k < 18; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 4'h0, 32'h300, 32'h0);
            checkOutput("starve_inst_grant", 64'(inst_bus.addr_ok), 64'(k % 9 == 8));
            checkOutput("starve_data_grant", 64'(data_bus.addr_ok), 64'(k % 9 != 8));
            if (inst_bus.data_ok) inst_resp++;
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        if (inst_bus.data_ok) inst_resp++;
        checkOutput("starve_inst_resp_count", 64'(inst_resp), 64'd2);
`endif

        // back-to-back accepts: data, inst, data
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h104, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h108, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("b2b_data_ok_1", 64'({inst_bus.data_ok, data_bus.data_ok}), 64'b01);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h10c, 32'h0);
        checkOutput("b2b_data_ok_2", 64'({inst_bus.data_ok, data_bus.data_ok}), 64'b10);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("b2b_data_ok_3", 64'({inst_bus.data_ok, data_bus.data_ok}), 64'b01);

        // reset while a data read is in flight
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        checkOutput("midrst_accept", 64'(data_bus.addr_ok), 64'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("midrst_data_ok_n1", 64'(data_bus.data_ok), 64'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("midrst_data_ok_n2", 64'(data_bus.data_ok), 64'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("midrst_idle", 64'({inst_bus.data_ok, data_bus.data_ok}), 64'b00);

        // random traffic with occasional resets
        repeat (3000) randomStep();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        inst_bus.req = 1'b0;
        data_bus.req = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
